// File: rtl/mem_stage_vlat_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_vlat_if
// Brief    : EX/MEM/WB handshake, data-response and forwarding bundle
// Revision : 1.0
// ============================================================================
interface mem_stage_vlat_if;
    logic         es_to_ms_valid;
    logic [160:0] es_to_ms_bus;
    logic         es_mem_req;
    logic         es_flush_inflt;
    logic         ms_allowin;
    logic         ms_valid;
    logic         ms_to_ws_valid;
    logic [154:0] ms_to_ws_bus;
    logic         ws_allowin;
    logic         data_data_ok;
    logic [31:0]  data_rdata;
    logic         ws_handle_ex;
    logic         ms_handle_ex;
    logic         ms_fwd_valid;
    logic [4:0]   ms_fwd_dest;
    logic [31:0]  ms_fwd_data;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, es_mem_req, es_flush_inflt,
        input  ws_allowin, data_data_ok, data_rdata, ws_handle_ex,
        output ms_allowin, ms_valid, ms_to_ws_valid, ms_to_ws_bus,
        output ms_handle_ex, ms_fwd_valid, ms_fwd_dest, ms_fwd_data
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, es_mem_req, es_flush_inflt,
        output ws_allowin, data_data_ok, data_rdata, ws_handle_ex,
        input  ms_allowin, ms_valid, ms_to_ws_valid, ms_to_ws_bus,
        input  ms_handle_ex, ms_fwd_valid, ms_fwd_dest, ms_fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_vlat.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_vlat
// Brief    : MEM stage for a variable-latency data memory; 1-entry response
//            buffer, post-flush discard counter, load extraction.
//            Optional macro MS_FWD_EN enables the MEM forwarding bus.
// Revision : 1.0
// ============================================================================
module mem_stage_vlat #(
    parameter int MAX_OUTST = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_stage_vlat_if.slave bus_if
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W:0] c_cnt_max = (CNT_W + 1)'(MAX_OUTST);

    logic [160:0]     r_bus;
    logic             r_ms_valid;
    logic             r_mem_req;
    logic             r_rbuf_valid;
    logic [31:0]      r_rbuf;
    logic [CNT_W-1:0] r_discard_cnt;

    logic        w_ex, w_bd, w_eret, w_mtc0, w_res_from_cp0, w_res_from_mem;
    logic        w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr, w_gr_we;
    logic [4:0]  w_exccode, w_dest;
    logic [7:0]  w_cp0_addr;
    logic [1:0]  w_addr_low;
    logic [31:0] w_badvaddr, w_cp0_wdata, w_alu_result, w_pc;

    assign {w_ex, w_exccode, w_bd, w_badvaddr, w_eret, w_mtc0, w_cp0_addr,
            w_cp0_wdata, w_res_from_cp0, w_res_from_mem, w_addr_low,
            w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr, w_gr_we, w_dest,
            w_alu_result, w_pc} = r_bus;

    logic w_resp_hit, w_ready_go, w_allowin, w_to_ws_valid, w_handoff, w_pend_flush;
    logic [31:0] w_raw;

    assign w_resp_hit    = bus_if.data_data_ok && (r_discard_cnt == '0) && r_ms_valid
                         && r_mem_req && !r_rbuf_valid;
    assign w_ready_go    = !r_mem_req || r_rbuf_valid || w_resp_hit;
    assign w_allowin     = !r_ms_valid || (w_ready_go && bus_if.ws_allowin);
    assign w_to_ws_valid = r_ms_valid && w_ready_go;
    assign w_handoff     = w_to_ws_valid && bus_if.ws_allowin;
    assign w_raw         = r_rbuf_valid ? r_rbuf : bus_if.data_rdata;
    // MEM's own request is still outstanding and will come back after the flush
    assign w_pend_flush  = r_ms_valid && r_mem_req && !r_rbuf_valid && !w_resp_hit;

    logic [CNT_W:0] w_cnt_add, w_cnt_next;
    logic           w_cnt_dec;

    assign w_cnt_add  = bus_if.ws_handle_ex
                      ? ({{CNT_W{1'b0}}, w_pend_flush} + {{CNT_W{1'b0}}, bus_if.es_flush_inflt})
                      : '0;
    assign w_cnt_dec  = bus_if.data_data_ok && (r_discard_cnt != '0);
    assign w_cnt_next = {1'b0, r_discard_cnt} + w_cnt_add - {{CNT_W{1'b0}}, w_cnt_dec};

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_lwl_data, w_lwr_data, w_load, w_final;
    logic [3:0]  w_lwl_we, w_lwr_we, w_rf_we;

    always_comb begin
        w_half = w_addr_low[1] ? w_raw[31:16] : w_raw[15:0];
        case (w_addr_low)
            2'd0: begin
                w_byte     = w_raw[7:0];
                w_lwl_data = {w_raw[7:0], 24'd0};  w_lwl_we = 4'b1000;
                w_lwr_data = w_raw;                w_lwr_we = 4'b1111;
            end
            2'd1: begin
                w_byte     = w_raw[15:8];
                w_lwl_data = {w_raw[15:0], 16'd0}; w_lwl_we = 4'b1100;
                w_lwr_data = {8'd0, w_raw[31:8]};  w_lwr_we = 4'b0111;
            end
            2'd2: begin
                w_byte     = w_raw[23:16];
                w_lwl_data = {w_raw[23:0], 8'd0};  w_lwl_we = 4'b1110;
                w_lwr_data = {16'd0, w_raw[31:16]}; w_lwr_we = 4'b0011;
            end
            default: begin
                w_byte     = w_raw[31:24];
                w_lwl_data = w_raw;                w_lwl_we = 4'b1111;
                w_lwr_data = {24'd0, w_raw[31:24]}; w_lwr_we = 4'b0001;
            end
        endcase

        w_load  = w_raw;
        w_rf_we = {4{w_gr_we}};
        if (w_lb)       w_load = {{24{w_byte[7]}}, w_byte};
        else if (w_lbu) w_load = {24'd0, w_byte};
        else if (w_lh)  w_load = {{16{w_half[15]}}, w_half};
        else if (w_lhu) w_load = {16'd0, w_half};
        else if (w_lwl) begin
            w_load  = w_lwl_data;
            w_rf_we = w_lwl_we;
        end else if (w_lwr) begin
            w_load  = w_lwr_data;
            w_rf_we = w_lwr_we;
        end
        w_final = w_res_from_mem ? w_load : w_alu_result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid    <= 1'b0;
            r_mem_req     <= 1'b0;
            r_rbuf_valid  <= 1'b0;
            r_discard_cnt <= '0;
            r_bus         <= '0;
        end else begin
            if (bus_if.ws_handle_ex)
                r_ms_valid <= 1'b0;
            else if (w_allowin)
                r_ms_valid <= bus_if.es_to_ms_valid;

            if (bus_if.es_to_ms_valid && w_allowin) begin
                r_bus     <= bus_if.es_to_ms_bus;
                r_mem_req <= bus_if.es_mem_req;
            end

            if (bus_if.ws_handle_ex || w_handoff)
                r_rbuf_valid <= 1'b0;
            else if (w_resp_hit && !bus_if.ws_allowin)
                r_rbuf_valid <= 1'b1;

            assert (w_cnt_next <= c_cnt_max);
            if (w_cnt_next > c_cnt_max)
                r_discard_cnt <= c_cnt_max[CNT_W-1:0];
            else
                r_discard_cnt <= w_cnt_next[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_resp_hit && !bus_if.ws_allowin)
            r_rbuf <= bus_if.data_rdata;
    end

    assign bus_if.ms_allowin     = w_allowin;
    assign bus_if.ms_valid       = r_ms_valid;
    assign bus_if.ms_to_ws_valid = w_to_ws_valid;
    assign bus_if.ms_handle_ex   = r_ms_valid && (w_ex || w_eret);
    assign bus_if.ms_to_ws_bus   = {r_ms_valid && w_ex, w_exccode, w_bd, w_badvaddr, w_eret,
                                    w_mtc0, w_cp0_addr, w_cp0_wdata, w_res_from_cp0,
                                    w_rf_we, w_dest, w_final, w_pc};

`ifdef MS_FWD_EN
    assign bus_if.ms_fwd_valid = r_ms_valid && w_gr_we && (w_dest != 5'd0) && w_ready_go
                               && !w_res_from_cp0;
    assign bus_if.ms_fwd_dest  = w_dest;
    assign bus_if.ms_fwd_data  = w_final;
`else
    assign bus_if.ms_fwd_valid = 1'b0;
    assign bus_if.ms_fwd_dest  = 5'd0;
    assign bus_if.ms_fwd_data  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_vlat.sv
`default_nettype none
// Bench for mem_stage_vlat: tagged in-order response model, directed scenarios
// followed by randomized EX/WB/memory traffic.
module tb_mem_stage_vlat;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_stage_vlat_if bif();
    mem_stage_vlat #(.MAX_OUTST(2)) dut (.clk(clk), .reset(reset), .bus_if(bif));

    typedef struct {
        logic [81:0] hi;
        logic [5:0]  op;
        logic        res_mem;
        logic [1:0]  al;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
        logic        mreq;
        int          id;
    } instr_t;

    int n_vec = 0;
    int n_err = 0;
    int next_id = 0;
    int q[$];                 // outstanding responses in return order; -1 = flushed owner
    instr_t exh, mi;
    bit exh_v = 0, mi_v = 0, mi_have = 0;
    logic [31:0] mi_data;
    bit d_ok = 0, d_flush = 0, d_wsal = 1;
    logic [31:0] d_rdata = 32'd0;
    bit e_resp, e_ready, e_allow;
    logic s_to_ws_valid;
    logic [154:0] s_bus;
    logic [3:0] lwl_we [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [3:0] lwr_we [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // k: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lwl, 6 lwr, 7 store, 8 alu
    function automatic instr_t mk_instr(int k, logic [1:0] al);
        instr_t t;
        logic [95:0] r;
        r         = {$urandom, $urandom, $urandom};
        t.hi      = r[81:0];
        t.al      = al;
        t.dest    = 5'($urandom);
        t.alu     = $urandom;
        t.pc      = $urandom;
        t.res_mem = (k <= 6);
        t.mreq    = (k <= 7);
        t.gr_we   = (k <= 6) ? 1'b1 : ((k == 7) ? 1'b0 : 1'($urandom));
        t.op      = (k >= 1 && k <= 6) ? (6'b100000 >> (k - 1)) : 6'd0;
        t.id      = -2;
        return t;
    endfunction

    task automatic present(input int k, input logic [1:0] al);
        exh   = mk_instr(k, al);
        exh_v = 1;
        if (exh.mreq) begin
            exh.id = next_id;
            next_id++;
            q.push_back(exh.id);
        end
    endtask

    // {rf_we, final_result} for an instruction given the raw response word
    function automatic logic [35:0] ref_result(instr_t t, logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        logic [3:0]  we;
        b  = raw[8*t.al +: 8];
        h  = t.al[1] ? raw[31:16] : raw[15:0];
        v  = raw;
        we = {4{t.gr_we}};
        case (t.op)
            6'b100000: v = {{24{b[7]}}, b};
            6'b010000: v = {24'd0, b};
            6'b001000: v = {{16{h[15]}}, h};
            6'b000100: v = {16'd0, h};
            6'b000010: begin v = raw << (8 * (3 - t.al)); we = lwl_we[t.al]; end
            6'b000001: begin v = raw >> (8 * t.al);       we = lwr_we[t.al]; end
            default: ;
        endcase
        if (!t.res_mem) v = t.alu;
        return {we, v};
    endfunction

    task automatic compare();
        logic [35:0]  r;
        logic [31:0]  raw;
        logic [154:0] eb;
        logic         fv;
        e_resp  = d_ok && (q.size() > 0) && mi_v && mi.mreq && !mi_have && (q[0] == mi.id);
        e_ready = !mi.mreq || mi_have || e_resp;
        e_allow = !mi_v || (e_ready && d_wsal);
        raw     = mi_have ? mi_data : d_rdata;
        r       = ref_result(mi, raw);
        eb      = {mi_v && mi.hi[81], mi.hi[80:0], r[35:32], mi.dest, r[31:0], mi.pc};
        s_to_ws_valid = bif.ms_to_ws_valid;
        s_bus         = bif.ms_to_ws_bus;
        chk("ms_valid", bif.ms_valid, mi_v);
        chk("ms_to_ws_valid", s_to_ws_valid, mi_v && e_ready);
        chk("ms_allowin", bif.ms_allowin, e_allow);
        chk("ms_handle_ex", bif.ms_handle_ex, mi_v && (mi.hi[81] || mi.hi[42]));
        if (mi_v && e_ready) chk("ms_to_ws_bus", s_bus, eb);
`ifdef MS_FWD_EN
        fv = mi_v && mi.gr_we && (mi.dest != 5'd0) && e_ready && !mi.hi[0];
        chk("ms_fwd_valid", bif.ms_fwd_valid, fv);
        if (fv) chk("ms_fwd_dest_data", {bif.ms_fwd_dest, bif.ms_fwd_data}, {mi.dest, r[31:0]});
`else
        fv = 1'b0;
        chk("ms_fwd_tied", {bif.ms_fwd_valid, bif.ms_fwd_dest, bif.ms_fwd_data}, {fv, 37'd0});
`endif
    endtask

    task automatic advance();
        if (d_ok && q.size() > 0) void'(q.pop_front());
        if (d_flush) begin
            foreach (q[j]) q[j] = -1;
            mi_v  = 0;
            exh_v = 0;
        end else begin
            if (mi_v && e_ready && d_wsal) mi_v = 0;
            else if (e_resp) begin
                mi_have = 1;
                mi_data = d_rdata;
            end
            if (exh_v && e_allow) begin
                mi      = exh;
                mi_v    = 1;
                mi_have = 0;
                exh_v   = 0;
            end
        end
    endtask

    task automatic step();
        bif.es_to_ms_valid = exh_v && !d_flush;
        bif.es_to_ms_bus   = {exh.hi, exh.res_mem, exh.al, exh.op, exh.gr_we, exh.dest, exh.alu, exh.pc};
        bif.es_mem_req     = exh_v && exh.mreq;
        bif.es_flush_inflt = d_flush && exh_v && exh.mreq;
        bif.ws_allowin     = d_wsal;
        bif.data_data_ok   = d_ok;
        bif.data_rdata     = d_rdata;
        bif.ws_handle_ex   = d_flush;
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        advance();
    endtask

    int k;

    initial begin
        exh = mk_instr(8, 2'd0);
        mi  = mk_instr(8, 2'd0);
        reset = 1'b1;
        bif.es_to_ms_valid = 0; bif.es_to_ms_bus = '0; bif.es_mem_req = 0;
        bif.es_flush_inflt = 0; bif.ws_allowin = 1; bif.data_data_ok = 0;
        bif.data_rdata = '0; bif.ws_handle_ex = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ms_valid", bif.ms_valid, 1'b0);
        chk("reset_to_ws_valid", bif.ms_to_ws_valid, 1'b0);
        chk("reset_handle_ex", bif.ms_handle_ex, 1'b0);
        chk("reset_fwd_valid", bif.ms_fwd_valid, 1'b0);
        chk("reset_allowin", bif.ms_allowin, 1'b1);
        @(posedge clk);
        #1;

        // lw, response three cycles after capture
        present(0, 2'd0); step();
        step(); chk("lw_wait1", s_to_ws_valid, 1'b0);
        step(); chk("lw_wait2", s_to_ws_valid, 1'b0);
        d_ok = 1; d_rdata = 32'h8000_00F0; step();
        chk("lw_valid", s_to_ws_valid, 1'b1);
        chk("lw_result", s_bus[63:32], 32'h8000_00F0);
        chk("lw_rf_we", s_bus[72:69], 4'b1111);
        d_ok = 0;

        // lb @3 answered while WB stalls; buffered word must be used
        present(1, 2'd3); step();
        d_ok = 1; d_rdata = 32'h80AB_CDEF; d_wsal = 0; step();
        chk("lb_hit_valid", s_to_ws_valid, 1'b1);
        d_ok = 0; d_rdata = 32'h0; step();
        chk("lb_buf_result", s_bus[63:32], 32'hFFFF_FF80);
        d_wsal = 1; step();
        chk("lb_handoff_result", s_bus[63:32], 32'hFFFF_FF80);

        // flush with MEM pending and EX in flight: two responses discarded
        present(0, 2'd0); step();
        present(0, 2'd0); d_flush = 1; step(); d_flush = 0;
        present(0, 2'd0); d_ok = 1; d_rdata = 32'hDEAD_0001; step();
        chk("flush_drop1_valid", s_to_ws_valid, 1'b0);
        d_rdata = 32'hDEAD_0002; step();
        chk("flush_drop2_valid", s_to_ws_valid, 1'b0);
        d_rdata = 32'h1234_5678; step();
        chk("flush_third_valid", s_to_ws_valid, 1'b1);
        chk("flush_third_result", s_bus[63:32], 32'h1234_5678);
        d_ok = 0;

        // lwl @1 and lwr @2
        present(5, 2'd1); step();
        d_ok = 1; d_rdata = 32'h1122_3344; step();
        chk("lwl_result", s_bus[63:32], 32'h3344_0000);
        chk("lwl_rf_we", s_bus[72:69], 4'b1100);
        d_ok = 0;
        present(6, 2'd2); step();
        d_ok = 1; step();
        chk("lwr_result", s_bus[63:32], 32'h0000_1122);
        chk("lwr_rf_we", s_bus[72:69], 4'b0011);
        d_ok = 0;

        // flush coinciding with a discarded response while count is 1
        present(0, 2'd0); step();
        d_flush = 1; step(); d_flush = 0;
        present(0, 2'd0); step();
        d_ok = 1; d_rdata = 32'hBAD0_0001; d_flush = 1; step(); d_flush = 0;
        chk("flush_ok_same_valid", s_to_ws_valid, 1'b0);
        d_rdata = 32'hBAD0_0002; step();
        d_ok = 0; present(0, 2'd0); step();
        d_ok = 1; d_rdata = 32'hCAFE_F00D; step();
        chk("after_drain_valid", s_to_ws_valid, 1'b1);
        chk("after_drain_result", s_bus[63:32], 32'hCAFE_F00D);
        d_ok = 0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!exh_v && $urandom_range(3) != 0) begin
                k = int'($urandom_range(8));
                if (k <= 7 && q.size() >= 2) k = 8;
                present(k, 2'($urandom));
            end
            d_ok    = (q.size() > 0) && ((q[0] == -1) || (mi_v && q[0] == mi.id))
                    && ($urandom_range(2) == 0);
            d_rdata = $urandom;
            d_wsal  = ($urandom_range(3) != 0);
            d_flush = ($urandom_range(19) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
